// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter and transaction sequencer in front of a shared SPI master.
// Picks one pending requester, captures its word, drives the master newd/din
// handshake, follows the frame through the synchronized cs, and returns a
// one-cycle ack (completed) or err (start timeout) to the granted requester.
module spi_txn_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 12,
  parameter int START_TO = 256,
  parameter int GAP_CYC  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] din_flat,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic              m_newd,
  output logic [DW-1:0]     m_din,
  input  logic              m_cs,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(START_TO + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    XFER   = 3'd2,
    DONE   = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] err_q, err_d;
  logic            newd_q, newd_d;
  logic [DW-1:0]   din_q, din_d;
  logic            busy_q;
  logic            cs_meta_q, cs_s_q;

  logic [DW-1:0]   words [NREQ];
  logic            any_req;
  logic [PW-1:0]   rr_win;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Unpack the flat requester data bus into per-requester words.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      words[i] = din_flat[i*DW +: DW];
    end
  end

  // Round-robin search: first set req bit at or above ptr, wrapping.
  always_comb begin
    any_req = 1'b0;
    rr_win  = '0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NREQ;
      if (!any_req && req[PW'(idx)]) begin
        any_req = 1'b1;
        rr_win  = PW'(idx);
      end
    end
  end

  // Two-flop synchronizer on the master's chip select; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta_q <= 1'b1;
      cs_s_q    <= 1'b1;
    end else begin
      cs_meta_q <= m_cs;
      cs_s_q    <= cs_meta_q;
    end
  end

  // Next-state and registered-output logic of the transaction sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    err_d     = '0;
    newd_d    = newd_q;
    din_d     = din_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d    = rr_win;
          gnt_d    = onehot(rr_win);
          din_d    = words[rr_win];
          newd_d   = 1'b1;
          to_cnt_d = '0;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!cs_s_q) begin
          newd_d  = 1'b0;
          state_d = XFER;
        end else if (to_cnt_q == TW'(START_TO - 1)) begin
          // Master never started the frame: abort and report to the granter.
          newd_d    = 1'b0;
          gnt_d     = '0;
          err_d     = onehot(win_q);
          ptr_d     = next_ptr(win_q);
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      XFER: begin
        if (cs_s_q) begin
          ack_d   = onehot(win_q);
          state_d = DONE;
        end
      end
      DONE: begin
        // ack is high during this cycle; it and gnt fall together on exit.
        gnt_d     = '0;
        ptr_d     = next_ptr(win_q);
        gap_cnt_d = '0;
        state_d   = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        newd_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      newd_q    <= 1'b0;
      din_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      newd_q    <= newd_d;
      din_q     <= din_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign gnt    = gnt_q;
  assign ack    = ack_q;
  assign err    = err_q;
  assign m_newd = newd_q;
  assign m_din  = din_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: a table of arbitration transactions
// plus hand-written sequences for timeout, reset mid-transfer and request drop.
module tb_spi_txn_arbiter;

  localparam int NREQ     = 4;
  localparam int DW       = 12;
  localparam int START_TO = 256;
  localparam int GAP_CYC  = 48;
  localparam int XFER_LEN = 24;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] din_flat;
  logic [NREQ-1:0]   gnt, ack, err;
  logic              m_newd;
  logic [DW-1:0]     m_din;
  logic              m_cs;
  logic              busy;

  spi_txn_arbiter #(
    .NREQ(NREQ), .DW(DW), .START_TO(START_TO), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .din_flat(din_flat),
    .gnt(gnt), .ack(ack), .err(err),
    .m_newd(m_newd), .m_din(m_din), .m_cs(m_cs), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [47:0] words;
    logic [3:0]  exp_gnt;
    logic [11:0] exp_din;
    logic [1:0]  exp_ptr;
  } vec_t;

  vec_t vecs [10];

  int n_pass  = 0;
  int n_total = 0;
  int cyc = 0;
  int ack_pulses = 0;
  int err_pulses = 0;
  int gnt_rises = 0;
  logic [NREQ-1:0] gnt_prev = '0;
  bit have_prev = 1'b0;
  int fall_cyc = 0;
  logic [DW-1:0] slave_dout;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse/edge monitors sampled away from the active edge.
  always @(negedge clk) begin
    if (ack != '0) ack_pulses <= ack_pulses + 1;
    if (err != '0) err_pulses <= err_pulses + 1;
    if (gnt != '0 && gnt_prev == '0) gnt_rises <= gnt_rises + 1;
    gnt_prev <= gnt;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  // One full transaction with a well-behaved master emulated by the bench.
  task automatic run_txn(input vec_t v, input bit drop, input string tag);
    int n;
    int a0;
    bit idle_start;
    idle_start = (busy === 1'b0);
    req = v.req;
    din_flat = v.words;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 300);
    if (gnt == '0) begin
      check({tag, "_grant_timeout"}, 32'(gnt), 32'(v.exp_gnt));
      return;
    end
    if (idle_start) check({tag, "_grant_latency"}, 32'(n), 32'd1);
    if (have_prev) check({tag, "_gap_ok"}, 32'((cyc - fall_cyc) >= GAP_CYC), 32'd1);
    check({tag, "_gnt"}, 32'(gnt), 32'(v.exp_gnt));
    check({tag, "_din"}, 32'(m_din), 32'(v.exp_din));
    check({tag, "_newd"}, 32'(m_newd), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    // Requester is free to change its word once granted.
    din_flat = ~v.words;
    repeat (2) @(negedge clk);
    check({tag, "_din_stable"}, 32'(m_din), 32'(v.exp_din));
    slave_dout = m_din;
    m_cs = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_newd_hold"}, 32'(m_newd), 32'd1);
    @(negedge clk);
    check({tag, "_newd_drop"}, 32'(m_newd), 32'd0);
    if (drop) req = '0;
    repeat (XFER_LEN) @(negedge clk);
    m_cs = 1'b1;
    a0 = ack_pulses;
    repeat (2) @(negedge clk);
    check({tag, "_ack_early"}, 32'(ack), 32'd0);
    @(negedge clk);
    check({tag, "_ack"}, 32'(ack), 32'(v.exp_gnt));
    check({tag, "_gnt_in_done"}, 32'(gnt), 32'(v.exp_gnt));
    @(negedge clk);
    check({tag, "_ack_end"}, 32'(ack), 32'd0);
    check({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
    check({tag, "_ptr"}, 32'(dut.ptr_q), 32'(v.exp_ptr));
    check({tag, "_ack_once"}, 32'(ack_pulses - a0), 32'd1);
    check({tag, "_slave_dout"}, 32'(slave_dout), 32'(v.exp_din));
    fall_cyc = cyc;
    have_prev = 1'b1;
  endtask

  initial begin
    localparam logic [47:0] W_CNT = 48'h004_003_002_001;
    localparam logic [47:0] W_MIX = 48'h444_333_A5C_111;
    int k;
    int a0, e0, g0;
    vec_t v;

    // Contention 0,1,2,3,0 then single, wrap-around and mixed patterns.
    vecs[0] = '{4'b1111, W_CNT, 4'b0001, 12'h001, 2'd1};
    vecs[1] = '{4'b1111, W_CNT, 4'b0010, 12'h002, 2'd2};
    vecs[2] = '{4'b1111, W_CNT, 4'b0100, 12'h003, 2'd3};
    vecs[3] = '{4'b1111, W_CNT, 4'b1000, 12'h004, 2'd0};
    vecs[4] = '{4'b1111, W_CNT, 4'b0001, 12'h001, 2'd1};
    vecs[5] = '{4'b0010, W_MIX, 4'b0010, 12'hA5C, 2'd2};
    vecs[6] = '{4'b0100, W_MIX, 4'b0100, 12'h333, 2'd3};
    vecs[7] = '{4'b0101, W_MIX, 4'b0001, 12'h111, 2'd1};
    vecs[8] = '{4'b0101, W_MIX, 4'b0100, 12'h333, 2'd3};
    vecs[9] = '{4'b1001, W_MIX, 4'b1000, 12'h444, 2'd0};

    rst = 1'b1;
    req = '0;
    din_flat = '0;
    m_cs = 1'b1;
    slave_dout = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_newd", 32'(m_newd), 32'd0);
    check("rst_din", 32'(m_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ptr", 32'(dut.ptr_q), 32'd0);
    check("rst_sync", 32'(dut.cs_s_q), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Request dropped mid-transfer: still one ack, no re-grant.
    v = '{4'b0001, W_MIX, 4'b0001, 12'h111, 2'd1};
    run_txn(v, 1'b1, "drop");
    g0 = gnt_rises;
    repeat (GAP_CYC + 10) @(negedge clk);
    check("drop_no_regrant", 32'(gnt_rises - g0), 32'd0);
    check("drop_idle", 32'(busy), 32'd0);
    have_prev = 1'b0;

    // Start timeout: cs never falls.
    wait_idle("to");
    a0 = ack_pulses;
    req = 4'b0100;
    din_flat = W_MIX;
    @(negedge clk);
    check("to_gnt", 32'(gnt), 32'b0100);
    k = 0;
    while (err == '0 && k < START_TO + 20) begin
      @(negedge clk);
      k++;
    end
    check("to_latency", 32'(k), 32'(START_TO));
    check("to_err", 32'(err), 32'b0100);
    check("to_gnt_clr", 32'(gnt), 32'd0);
    check("to_newd_clr", 32'(m_newd), 32'd0);
    check("to_ptr", 32'(dut.ptr_q), 32'd3);
    req = '0;
    @(negedge clk);
    check("to_err_pulse", 32'(err), 32'd0);
    k = 1;
    while (busy !== 1'b0 && k < GAP_CYC + 20) begin
      @(negedge clk);
      k++;
    end
    check("to_gap_len", 32'(k), 32'(GAP_CYC));
    check("to_no_ack", 32'(ack_pulses - a0), 32'd0);

    // Reset asserted for one cycle in the middle of a frame.
    wait_idle("rx");
    req = 4'b0010;
    @(negedge clk);
    check("rx_gnt", 32'(gnt), 32'b0010);
    m_cs = 1'b0;
    repeat (5) @(negedge clk);
    check("rx_in_xfer", 32'(m_newd), 32'd0);
    a0 = ack_pulses;
    e0 = err_pulses;
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    check("rx_gnt_clr", 32'(gnt), 32'd0);
    check("rx_newd", 32'(m_newd), 32'd0);
    check("rx_busy", 32'(busy), 32'd0);
    check("rx_ptr", 32'(dut.ptr_q), 32'd0);
    check("rx_din", 32'(m_din), 32'd0);
    repeat (4) @(negedge clk);
    m_cs = 1'b1;
    repeat (GAP_CYC + 10) @(negedge clk);
    check("rx_no_ack", 32'(ack_pulses - a0), 32'd0);
    check("rx_no_err", 32'(err_pulses - e0), 32'd0);
    check("rx_still_idle", 32'(busy), 32'd0);

    // Normal service resumes after the reset.
    v = '{4'b0100, W_MIX, 4'b0100, 12'h333, 2'd3};
    run_txn(v, 1'b1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute guard so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Round-robin arbiter and transaction sequencer that shares one 12-bit SPI master between several requesters. It sits in the `clk` domain in front of the master. It selects one pending request and captures that requester's word. It drives the master's `newd`/`din` handshake, tracks the transfer through the master's `cs`, and returns a one-cycle completion or error pulse to the granted requester.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters (2..8)
- `DW`, 12 — data word width; must match the master `din` width
- `START_TO`, 256 — `clk` cycles allowed in `LAUNCH` for `cs` to go low before abort
- `GAP_CYC`, 48 — idle `clk` cycles enforced between transactions; must be at least 2 master `sclk` periods

Ports:
- `clk` in 1 — system clock
- `rst` in 1 — reset: synchronous, active-high; clock: `clk`
- `req` in `NREQ` — per-requester request level
- `din_flat` in `NREQ*DW` — requester *i* data on bits `[i*DW +: DW]`
- `gnt` out `NREQ` — one-hot grant, held from `LAUNCH` entry through `DONE`
- `ack` out `NREQ` — one-cycle pulse to the granter on successful completion
- `err` out `NREQ` — one-cycle pulse to the granter on start timeout
- `m_newd` out 1 — to master `newd`
- `m_din` out `DW` — to master `din`
- `m_cs` in 1 — from master `cs` (active-low frame)
- `busy` out 1 — high in any state except `IDLE`

## Operation
- Reset values: `gnt`=0, `ack`=0, `err`=0, `m_newd`=0, `m_din`=0, `busy`=0, state=`IDLE`, rr pointer `ptr`=0, sync flops=1.
- `m_cs` passes through a 2-flop synchronizer; `cs_s` denotes the second-stage output.
- Arbitration is round-robin:
  - search `req` from index `ptr` upward, wrapping modulo `NREQ`; the first set bit wins;
  - `ptr` is updated to (winner+1) mod `NREQ` when the transaction ends, whether by ack or err.
- States:
  - `IDLE`: if any `req` bit is set, latch winner index, set `gnt[winner]`, register `m_din` = winner's word, set `m_newd`=1, go to `LAUNCH`.
  - `LAUNCH`: hold `m_newd`=1 and `m_din` stable.
    - If `cs_s`==0, clear `m_newd` and go to `XFER`.
    - Otherwise, when the timeout counter reaches `START_TO`-1, clear `m_newd`, pulse `err[winner]`, go to `GAP`.
  - `XFER`: wait for `cs_s`==1, then go to `DONE`.
  - `DONE`: pulse `ack[winner]` for one cycle, clear `gnt`, update `ptr`, go to `GAP`.
  - `GAP`: count `GAP_CYC` cycles with `gnt`=0 and `m_newd`=0, then go to `IDLE`. This lets the master return to idle and finish `cs` recovery.
- The data word is captured at grant. The requester may change `din` after `gnt` rises.
- Requester contract: hold `req` until `ack` or `err`.
  - If `req` drops mid-transaction, the transfer still completes and `ack` still pulses.
  - A `req` still high after `ack` is treated as a new request in the next arbitration.
- `m_din` keeps its last value outside `LAUNCH`/`XFER`; the master ignores it while `newd`=0.
- Reset asserted in any state returns all outputs and state to reset values on the next edge. No `ack`/`err` is produced for the aborted transaction.
- Unused/illegal state encodings go to `IDLE` with outputs cleared.

## Timing
- Grant latency: `req` high at edge *n* gives `gnt`, `m_newd`, `m_din` valid after edge *n*+1.
- `m_cs` falling reaches `XFER` 3 edges after it is sampled low: 2 sync stages plus 1 state register.
- `ack` goes high 3 edges after `m_cs` rises, lasts exactly 1 cycle, and coincides with `gnt` clearing.
- Minimum request-to-request spacing is the full transfer time plus `GAP_CYC`+2 cycles.
- The timeout counter clears on `LAUNCH` entry. `err` fires on the cycle the counter equals `START_TO`-1, i.e. `START_TO` cycles after `LAUNCH` entry.
- `busy` equals (state != `IDLE`), registered.

## Test plan
- Single requester: `req[1]`=1, `din[1]`=12'hA5C with master and slave attached. `gnt`=4'b0010, `m_newd` drops after `cs` falls, one `ack[1]` pulse, slave `dout`=12'hA5C with `done`=1, `ptr`=2.
- Contention: `req`=4'b1111 held, words 12'h001..12'h004. Grants occur in order 0,1,2,3,0. Each `ack` matches its slave `dout`, and there are ≥`GAP_CYC` idle cycles between `gnt` pulses.
- Wrap-around: `ptr`=3 (after serving req 2), `req`=4'b0101. Req 0 is granted before req 2.
- Start timeout: `m_cs` tied to 1, `req[2]`=1. `err[2]` pulses exactly `START_TO` cycles after `LAUNCH` entry, no `ack`, returns to `IDLE` after `GAP_CYC`, `ptr`=3.
- Reset mid-`XFER`: assert `rst` for 1 cycle during the transfer. The next edge gives `gnt`=0, `m_newd`=0, `busy`=0, `ptr`=0, and no `ack`/`err` pulse ever appears for that transaction.
- Request drop: deassert `req[0]` in `XFER`. Transfer completes and `ack[0]` still pulses once; no second grant to req 0.
